// File: rtl/mbldcm_freq2div_pkg.sv
// ---------------------------------------------------------------------------
// mbldcm_freq2div_pkg
// Shared definitions for the multi-channel frequency-to-divider converter:
//   - clog2 / maxi     : elaboration-time arithmetic helpers
//   - calcN / calcW    : derived dividend N = clock/stages and its bit width
//   - tDivState        : scheduler FSM encoding (IDLE / DIV / STORE)
// ---------------------------------------------------------------------------
package mbldcm_freq2div_pkg;

   // Ceiling log2; clog2(1) = 0.
   function automatic int clog2(input longint v);
      longint x;
      int     r;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >>> 1;
      end
      return r;
   endfunction

   function automatic int maxi(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Dividend shared by every channel: clock ticks per commutation stage.
   function automatic longint calcN(input longint freqClock, input longint stages);
      return freqClock / stages;
   endfunction

   // Quotient width needed to hold any N / Freq (Freq >= 1).
   function automatic int calcW(input longint n);
      return clog2(n + 1);
   endfunction

   typedef enum logic [1:0] {
      stIdle  = 2'd0,
      stDiv   = 2'd1,
      stStore = 2'd2
   } tDivState;

endpackage

// File: rtl/mbldcm_freq2div_multi_udiv.sv
// ---------------------------------------------------------------------------
// mbldcm_seq_udiv
// Start/done restoring unsigned divider, one quotient bit per clock, MSB
// first. A division takes exactly pWidthNum clocks after the iStart edge;
// oLast is high during the clock whose edge computes the final bit, so the
// quotient/remainder are valid on the following cycle and hold until the
// next iStart.
//   iClock, iReset_n : clock, synchronous active-low reset (aborts division)
//   iStart           : load iNum/iDen and begin
//   iNum             : numerator, pWidthNum bits
//   iDen             : denominator, pWidthDen bits (must be non-zero)
//   oLast            : final step is being taken this cycle
//   oQuot, oRem      : quotient (pWidthNum bits), remainder (pWidthNum+1 bits)
// ---------------------------------------------------------------------------
module mbldcm_seq_udiv
   import mbldcm_freq2div_pkg::*;
#(
   parameter int pWidthNum = 22,
   parameter int pWidthDen = 32
) (
   input  logic                 iClock,
   input  logic                 iReset_n,
   input  logic                 iStart,
   input  logic [pWidthNum-1:0] iNum,
   input  logic [pWidthDen-1:0] iDen,
   output logic                 oLast,
   output logic [pWidthNum-1:0] oQuot,
   output logic [pWidthNum:0]   oRem
);

   // Compare wide enough for both the shifted remainder and a full-width
   // denominator, so large targets are never truncated.
   localparam int cCmpW = maxi(pWidthNum + 1, pWidthDen);
   localparam int cCntW = maxi(clog2(pWidthNum), 1);

   logic [pWidthNum-1:0] rNum;
   logic [pWidthDen-1:0] rDen;
   logic [pWidthNum:0]   rRem;
   logic [pWidthNum-1:0] rQuot;
   logic [cCntW-1:0]     rCnt;
   logic                 rBusy;

   logic [pWidthNum:0]   remShift;
   logic [cCmpW-1:0]     remExt, denExt, diffExt;
   logic                 geDen;

   always_comb begin
      remShift = {rRem[pWidthNum-1:0], rNum[pWidthNum-1]};
      remExt   = '0;
      remExt[pWidthNum:0] = remShift;
      denExt   = '0;
      denExt[pWidthDen-1:0] = rDen;
      geDen    = (remExt >= denExt);
      diffExt  = remExt - denExt;
   end

   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         rNum  <= '0;
         rDen  <= '0;
         rRem  <= '0;
         rQuot <= '0;
         rCnt  <= '0;
         rBusy <= 1'b0;
      end else if (iStart) begin
         rNum  <= iNum;
         rDen  <= iDen;
         rRem  <= '0;
         rQuot <= '0;
         rCnt  <= cCntW'(pWidthNum - 1);
         rBusy <= 1'b1;
      end else if (rBusy) begin
         rNum  <= rNum << 1;
         rRem  <= geDen ? diffExt[pWidthNum:0] : remShift;
         rQuot <= (rQuot << 1) | pWidthNum'(geDen);
         if (rCnt == '0) rBusy <= 1'b0;
         else            rCnt  <= rCnt - 1'b1;
      end
   end

   assign oLast = rBusy && (rCnt == '0);
   assign oQuot = rQuot;
   assign oRem  = rRem;

endmodule

// File: rtl/mbldcm_freq2div_multi.sv
// ---------------------------------------------------------------------------
// mbldcm_freq2div_multi
// Per-channel target frequency registers converted to commutation clock
// dividers Div = N / Freq, N = pFreqClock / pTotalPhaseStages. One shared
// sequential divider is time-multiplexed round-robin over pending channels.
// Outputs of a channel only change on its STORE cycle; a rewrite of a
// channel whose conversion is in flight discards that result and requeues.
//   iClock, iReset_n : clock, synchronous active-low reset
//   iWrEn/iWrCh/iWrFreq : target write (out-of-range channel ignored)
//   iRdCh / oRdFreq  : combinational readback of stored target
//   oReflected       : per channel, oDiv/oStop correspond to stored target
//   oDiv             : flat bus, channel c at [c*pWidthDiv +: pWidthDiv]
//   oStop            : per channel, target is zero
//   oBusy            : shared divider in DIV or STORE
// ---------------------------------------------------------------------------
module mbldcm_freq2div_multi
   import mbldcm_freq2div_pkg::*;
#(
   parameter logic [31:0] pFreqClock        = 32'd50000000,
   parameter logic [3:0]  pTotalPhaseStages = 4'd12,
   parameter int          pChannels         = 2,
   parameter int          pWidthFreq        = 32,
   parameter int          pWidthDiv         = 32,
   parameter int          pRoundNearest     = 0
) (
   input  logic                           iClock,
   input  logic                           iReset_n,
   input  logic                           iWrEn,
   input  logic [((pChannels > 1) ? clog2(pChannels) : 1)-1:0] iWrCh,
   input  logic [pWidthFreq-1:0]          iWrFreq,
   input  logic [((pChannels > 1) ? clog2(pChannels) : 1)-1:0] iRdCh,
   output logic [pWidthFreq-1:0]          oRdFreq,
   output logic [pChannels-1:0]           oReflected,
   output logic [pChannels*pWidthDiv-1:0] oDiv,
   output logic [pChannels-1:0]           oStop,
   output logic                           oBusy
);

   localparam int     cChW  = (pChannels > 1) ? clog2(pChannels) : 1;
   localparam longint cN    = calcN(longint'(pFreqClock), longint'(pTotalPhaseStages));
   localparam int     cW    = calcW(cN);
   localparam int     cCmpW = maxi(cW + 2, pWidthFreq);
   localparam int     cSatW = maxi(cW + 1, pWidthDiv);
   localparam logic [cW-1:0] cNum = cW'(cN);

   tDivState rState, nState;

   logic [pChannels-1:0][pWidthFreq-1:0] rFreq;
   logic [pChannels-1:0][pWidthDiv-1:0]  rDiv;
   logic [pChannels-1:0]                 rPending, rReflected, rStop;
   logic [cChW-1:0]                      rCurCh, rRrPtr, selCh, nextPtr;
   logic [pWidthFreq-1:0]                rCurFreq;
   logic                                 rDirty;

   logic anyPending, selLoad, udivStart, udivLast, wrValid, wrHitCur;
   logic [cW-1:0] udivQuot;
   logic [cW:0]   udivRem;

   assign wrValid  = iWrEn && (int'(iWrCh) < pChannels);
   assign wrHitCur = wrValid && (iWrCh == rCurCh);
   assign nextPtr  = (int'(rCurCh) + 1 >= pChannels) ? '0 : rCurCh + 1'b1;

   // Round-robin pick: first pending channel at or after the pointer.
   // Scanning offsets high-to-low lets the smallest offset win.
   always_comb begin
      int idx;
      idx        = 0;
      selCh      = '0;
      anyPending = 1'b0;
      for (int i = pChannels - 1; i >= 0; i--) begin
         idx = int'(rRrPtr) + i;
         if (idx >= pChannels) idx = idx - pChannels;
         if (rPending[idx]) begin
            anyPending = 1'b1;
            selCh      = cChW'(idx);
         end
      end
   end

   always_ff @(posedge iClock) begin
      if (!iReset_n) rState <= stIdle;
      else           rState <= nState;
   end

   always_comb begin
      nState    = rState;
      selLoad   = 1'b0;
      udivStart = 1'b0;
      case (rState)
         stIdle: begin
            if (anyPending) begin
               selLoad = 1'b1;
               if (rFreq[selCh] == '0) begin
                  nState = stStore;
               end else begin
                  nState    = stDiv;
                  udivStart = 1'b1;
               end
            end
         end
         stDiv:   if (udivLast) nState = stStore;
         stStore: nState = stIdle;
         default: nState = stIdle;
      endcase
   end

   mbldcm_seq_udiv #(
      .pWidthNum (cW),
      .pWidthDen (pWidthFreq)
   ) uDiv (
      .iClock   (iClock),
      .iReset_n (iReset_n),
      .iStart   (udivStart),
      .iNum     (cNum),
      .iDen     (rFreq[selCh]),
      .oLast    (udivLast),
      .oQuot    (udivQuot),
      .oRem     (udivRem)
   );

   // Rounding, floor-at-1 and saturation of the raw quotient.
   logic [cCmpW-1:0]     twoRemExt, freqExt;
   logic [cW:0]          qRnd;
   logic [cSatW-1:0]     qExt, qMax;
   logic [pWidthDiv-1:0] storeDiv;

   always_comb begin
      twoRemExt = '0;
      twoRemExt[cW+1:0] = {udivRem, 1'b0};
      freqExt   = '0;
      freqExt[pWidthFreq-1:0] = rCurFreq;
      qRnd      = {1'b0, udivQuot};
      if ((pRoundNearest != 0) && (twoRemExt >= freqExt)) qRnd = qRnd + (cW+1)'(1);
      if (qRnd == '0) qRnd = (cW+1)'(1);
      qExt      = '0;
      qExt[cW:0] = qRnd;
      qMax      = '0;
      qMax[pWidthDiv-1:0] = '1;
      if (qExt > qMax) qExt = qMax;
      storeDiv  = qExt[pWidthDiv-1:0];
   end

   always_ff @(posedge iClock) begin
      if (!iReset_n) begin
         rFreq      <= '0;
         rPending   <= '0;
         rDirty     <= 1'b0;
         rReflected <= '1;
         rStop      <= '1;
         for (int c = 0; c < pChannels; c++) rDiv[c] <= pWidthDiv'(1);
         rRrPtr     <= '0;
         rCurCh     <= '0;
         rCurFreq   <= '0;
      end else begin
         if (selLoad) begin
            rCurCh          <= selCh;
            rCurFreq        <= rFreq[selCh];
            rPending[selCh] <= 1'b0;
         end
         if (rState == stStore) begin
            rDirty <= 1'b0;
            rRrPtr <= nextPtr;
            // A write landing on this very edge supersedes the result.
            if (!rDirty && !wrHitCur) begin
               rReflected[rCurCh] <= 1'b1;
               if (rCurFreq == '0) begin
                  rStop[rCurCh] <= 1'b1;
                  rDiv[rCurCh]  <= pWidthDiv'(1);
               end else begin
                  rStop[rCurCh] <= 1'b0;
                  rDiv[rCurCh]  <= storeDiv;
               end
            end
         end
         // Placed last so a write overrides the pending clear and the
         // reflected set above for the same channel.
         if (wrValid) begin
            rFreq[iWrCh]      <= iWrFreq;
            rPending[iWrCh]   <= 1'b1;
            rReflected[iWrCh] <= 1'b0;
            if (((rState == stDiv) && (iWrCh == rCurCh)) ||
                (selLoad && (iWrCh == selCh)))
               rDirty <= 1'b1;
         end
      end
   end

   always_comb begin
      oRdFreq = '0;
      if (int'(iRdCh) < pChannels) oRdFreq = rFreq[iRdCh];
   end

   assign oDiv       = rDiv;
   assign oStop      = rStop;
   assign oReflected = rReflected;
   assign oBusy      = (rState != stIdle);

endmodule
